// File: rtl/ysyx_23060203_pkg.sv
// Shared EXU constants and types: datapath width, ROB sizing defaults, channel indices.
package ysyx_23060203_pkg;

   localparam int unsigned XLEN       = 32;
   localparam int unsigned ROB_DEPTH  = 4;
   localparam int unsigned ROB_NUM_FU = 3;

   typedef enum logic [1:0] {
      FU_LSU = 2'd0,
      FU_MUL = 2'd1,
      FU_DIV = 2'd2
   } fu_e;

endpackage

// File: rtl/ysyx_23060203_exu_rob.sv
// EXU reorder buffer: dispatches issued ops to LSU/MUL/DIV channels, collects
// out-of-order results by tag and commits them to the WBU in allocation order.
module ysyx_23060203_exu_rob #(
   parameter int unsigned NUM_FU = ysyx_23060203_pkg::ROB_NUM_FU,
   parameter int unsigned DEPTH  = ysyx_23060203_pkg::ROB_DEPTH,
   parameter int unsigned XLEN   = ysyx_23060203_pkg::XLEN,
   parameter int unsigned TAGW   = $clog2(DEPTH)
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       flush,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [$clog2(NUM_FU)-1:0]  in_fu,
   input  logic [4:0]                 in_rd,
   input  logic [31:0]                in_pc,
   output logic [NUM_FU-1:0]          fu_req_valid,
   input  logic [NUM_FU-1:0]          fu_req_ready,
   output logic [TAGW-1:0]            fu_req_tag,
   output logic                       fu_flush,
   input  logic [NUM_FU-1:0]          fu_resp_valid,
   input  logic [NUM_FU*TAGW-1:0]     fu_resp_tag,
   input  logic [NUM_FU*XLEN-1:0]     fu_resp_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [4:0]                 out_rd,
   output logic [XLEN-1:0]            out_data,
   output logic [31:0]                out_pc,
   output logic [31:0]                rd_busy
);

   import ysyx_23060203_pkg::*;

   localparam int unsigned FUW  = $clog2(NUM_FU);
   localparam int unsigned CNTW = $clog2(DEPTH + 1);

   logic [DEPTH-1:0] valid_q, valid_d;
   logic [DEPTH-1:0] done_q, done_d;
   logic [4:0]       rd_q   [DEPTH];
   logic [31:0]      pc_q   [DEPTH];
   logic [XLEN-1:0]  data_q [DEPTH];

   logic [TAGW-1:0]  head_q, head_d;
   logic [TAGW-1:0]  tail_q, tail_d;
   logic [CNTW-1:0]  count_q, count_d;

   logic             full;
   logic             sel_ready;
   logic             enq;
   logic             deq;
   logic [DEPTH-1:0] resp_hit;
   logic [XLEN-1:0]  resp_data [DEPTH];
   logic [TAGW-1:0]  resp_tag;

   assign full = (count_q == CNTW'(DEPTH));

   // Channel select; an out-of-range in_fu simply never dispatches.
   always_comb begin
      sel_ready    = 1'b0;
      fu_req_valid = '0;
      for (int i = 0; i < NUM_FU; i++) begin
         if (in_fu == FUW'(i)) begin
            sel_ready       = fu_req_ready[i];
            fu_req_valid[i] = in_valid & ~flush & ~full;
         end
      end
   end

   assign in_ready   = ~flush & ~full & sel_ready;
   assign enq        = in_valid & in_ready;
   assign fu_req_tag = tail_q;
   assign fu_flush   = flush;

   assign out_valid = ~flush & valid_q[head_q] & done_q[head_q];
   assign deq       = out_valid & out_ready;
   assign out_rd    = rd_q[head_q];
   assign out_data  = data_q[head_q];
   assign out_pc    = pc_q[head_q];

   // Highest channel first so the lowest channel index wins a duplicate tag.
   always_comb begin
      resp_hit = '0;
      resp_tag = '0;
      for (int e = 0; e < DEPTH; e++) begin
         resp_data[e] = '0;
      end
      for (int i = NUM_FU - 1; i >= 0; i--) begin
         resp_tag = fu_resp_tag[i*TAGW +: TAGW];
         if (fu_resp_valid[i] && valid_q[resp_tag]) begin
            resp_hit[resp_tag]  = 1'b1;
            resp_data[resp_tag] = fu_resp_data[i*XLEN +: XLEN];
         end
      end
   end

   always_comb begin
      valid_d = valid_q;
      done_d  = done_q | resp_hit;
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (deq) begin
         valid_d[head_q] = 1'b0;
         done_d[head_q]  = 1'b0;
         head_d          = head_q + TAGW'(1);
      end
      if (enq) begin
         valid_d[tail_q] = 1'b1;
         done_d[tail_q]  = 1'b0;
         tail_d          = tail_q + TAGW'(1);
      end
      unique case ({enq, deq})
         2'b10:   count_d = count_q + CNTW'(1);
         2'b01:   count_d = count_q - CNTW'(1);
         default: count_d = count_q;
      endcase
      if (flush) begin
         valid_d = '0;
         done_d  = '0;
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         valid_q <= '0;
         done_q  <= '0;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         valid_q <= valid_d;
         done_q  <= done_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Payload storage is qualified by valid/done, so it carries no reset.
   always_ff @(posedge clock) begin
      for (int e = 0; e < DEPTH; e++) begin
         if (enq && (tail_q == TAGW'(e))) begin
            rd_q[e] <= in_rd;
            pc_q[e] <= in_pc;
         end
         if (resp_hit[e]) begin
            data_q[e] <= resp_data[e];
         end
      end
   end

   always_comb begin
      rd_busy = '0;
      for (int e = 0; e < DEPTH; e++) begin
         if (valid_q[e]) begin
            rd_busy[rd_q[e]] = 1'b1;
         end
      end
      rd_busy[0] = 1'b0;
   end

endmodule

// File: tb/tb_ysyx_23060203_exu_rob.sv
// Self-checking bench for the EXU reorder buffer: directed scenarios plus a
// randomized run against a tag-indexed circular-queue reference model.
module tb_ysyx_23060203_exu_rob;
   import ysyx_23060203_pkg::*;

   localparam int NF = 3;
   localparam int D  = 4;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [1:0]  in_fu = 2'd0;
   logic [4:0]  in_rd = 5'd0;
   logic [31:0] in_pc = 32'd0;
   logic [2:0]  fu_req_valid;
   logic [2:0]  fu_req_ready = 3'b111;
   logic [1:0]  fu_req_tag;
   logic        fu_flush;
   logic [2:0]  fu_resp_valid = 3'b000;
   logic [5:0]  fu_resp_tag = 6'd0;
   logic [95:0] fu_resp_data = 96'd0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [4:0]  out_rd;
   logic [31:0] out_data;
   logic [31:0] out_pc;
   logic [31:0] rd_busy;

   int n_cmp = 0;
   int n_fail = 0;

   ysyx_23060203_exu_rob dut (
      .clock         (clock),
      .reset         (reset),
      .flush         (flush),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_fu         (in_fu),
      .in_rd         (in_rd),
      .in_pc         (in_pc),
      .fu_req_valid  (fu_req_valid),
      .fu_req_ready  (fu_req_ready),
      .fu_req_tag    (fu_req_tag),
      .fu_flush      (fu_flush),
      .fu_resp_valid (fu_resp_valid),
      .fu_resp_tag   (fu_resp_tag),
      .fu_resp_data  (fu_resp_data),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_rd        (out_rd),
      .out_data      (out_data),
      .out_pc        (out_pc),
      .rd_busy       (rd_busy)
   );

   always #5 clock = ~clock;

   // Reference model: entries indexed by tag, head/tail as plain modulo counters.
   bit          m_valid [D];
   bit          m_done  [D];
   logic [4:0]  m_rd    [D];
   logic [31:0] m_pc    [D];
   logic [31:0] m_data  [D];
   int          m_head = 0;
   int          m_tail = 0;
   int          m_count = 0;

   function automatic bit exp_in_ready();
      if (flush || m_count == D || in_fu >= NF) return 1'b0;
      return fu_req_ready[in_fu] === 1'b1;
   endfunction

   function automatic logic [2:0] exp_req_valid();
      if (!in_valid || flush || m_count == D || in_fu >= NF) return 3'b000;
      return 3'(1 << in_fu);
   endfunction

   function automatic bit exp_out_valid();
      return !flush && m_valid[m_head] && m_done[m_head];
   endfunction

   function automatic logic [31:0] exp_busy();
      logic [31:0] b = 32'd0;
      for (int e = 0; e < D; e++) begin
         if (m_valid[e] && m_rd[e] != 5'd0) b[m_rd[e]] = 1'b1;
      end
      return b;
   endfunction

   task automatic model_edge();
      bit commit;
      bit enq;
      bit taken [D];
      logic [1:0] tag;
      commit = exp_out_valid() && out_ready;
      enq    = in_valid && exp_in_ready();
      if (reset || flush) begin
         for (int e = 0; e < D; e++) begin
            m_valid[e] = 1'b0;
            m_done[e]  = 1'b0;
         end
         m_head = 0;
         m_tail = 0;
         m_count = 0;
         return;
      end
      for (int e = 0; e < D; e++) taken[e] = 1'b0;
      for (int c = 0; c < NF; c++) begin
         tag = fu_resp_tag[c*2 +: 2];
         if (fu_resp_valid[c] && m_valid[tag] && !taken[tag]) begin
            taken[tag]  = 1'b1;
            m_done[tag] = 1'b1;
            m_data[tag] = fu_resp_data[c*32 +: 32];
         end
      end
      if (commit) begin
         m_valid[m_head] = 1'b0;
         m_done[m_head]  = 1'b0;
         m_head = (m_head + 1) % D;
         m_count--;
      end
      if (enq) begin
         m_valid[m_tail] = 1'b1;
         m_done[m_tail]  = 1'b0;
         m_rd[m_tail]    = in_rd;
         m_pc[m_tail]    = in_pc;
         m_tail = (m_tail + 1) % D;
         m_count++;
      end
   endtask

   task automatic tick();
      @(posedge clock);
      model_edge();
      #1;
   endtask

   task automatic idle();
      in_valid = 1'b0;
      flush = 1'b0;
      fu_resp_valid = 3'b000;
      out_ready = 1'b0;
   endtask

   task automatic do_reset();
      idle();
      fu_req_ready = 3'b111;
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic set_issue(input logic [1:0] fu, input logic [4:0] rd, input logic [31:0] pc);
      in_valid = 1'b1;
      in_fu = fu;
      in_rd = rd;
      in_pc = pc;
   endtask

   task automatic set_resp(input int ch, input logic [1:0] tag, input logic [31:0] data);
      fu_resp_valid[ch] = 1'b1;
      fu_resp_tag[ch*2 +: 2] = tag;
      fu_resp_data[ch*32 +: 32] = data;
   endtask

   task automatic test_reset();
      idle();
      reset = 1'b1;
      in_fu = FU_LSU;
      tick();
      tick();
      n_cmp++;
      if (out_valid !== 1'b0) begin
         n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid);
      end
      n_cmp++;
      if (rd_busy !== 32'd0) begin
         n_fail++; $display("FAIL reset_rd_busy: got %h want 0", rd_busy);
      end
      reset = 1'b0;
      #1;
      n_cmp++;
      if (in_ready !== 1'b1) begin
         n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
      end
      n_cmp++;
      if (fu_req_tag !== 2'd0) begin
         n_fail++; $display("FAIL reset_tag: got %0d want 0", fu_req_tag);
      end
   endtask

   task automatic test_basic();
      do_reset();
      set_issue(FU_MUL, 5'd5, 32'h8000_0000);
      #1;
      n_cmp++;
      if (fu_req_valid !== 3'b010 || fu_req_tag !== 2'd0 || in_ready !== 1'b1) begin
         n_fail++; $display("FAIL basic_dispatch: got v=%b tag=%0d rdy=%b want v=010 tag=0 rdy=1",
                            fu_req_valid, fu_req_tag, in_ready);
      end
      tick();
      idle();
      #1;
      n_cmp++;
      if (rd_busy !== 32'h20 || out_valid !== 1'b0) begin
         n_fail++; $display("FAIL basic_pending: got busy=%h ov=%b want busy=20 ov=0",
                            rd_busy, out_valid);
      end
      set_resp(1, 2'd0, 32'h1234);
      #1;
      n_cmp++;
      if (out_valid !== 1'b0) begin
         n_fail++; $display("FAIL basic_resp_latency: got %b want 0", out_valid);
      end
      tick();
      idle();
      out_ready = 1'b1;
      #1;
      n_cmp++;
      if (out_valid !== 1'b1 || out_rd !== 5'd5 || out_data !== 32'h1234 ||
          out_pc !== 32'h8000_0000) begin
         n_fail++; $display("FAIL basic_commit: got ov=%b rd=%0d data=%h pc=%h want 1 5 1234 80000000",
                            out_valid, out_rd, out_data, out_pc);
      end
      tick();
      idle();
      #1;
      n_cmp++;
      if (rd_busy !== 32'd0 || out_valid !== 1'b0) begin
         n_fail++; $display("FAIL basic_after_commit: got busy=%h ov=%b want 0 0", rd_busy, out_valid);
      end
   endtask

   task automatic test_out_of_order();
      do_reset();
      set_issue(FU_DIV, 5'd3, 32'h100);
      #1;
      n_cmp++;
      if (fu_req_tag !== 2'd0) begin
         n_fail++; $display("FAIL ooo_tag0: got %0d want 0", fu_req_tag);
      end
      tick();
      set_issue(FU_LSU, 5'd4, 32'h104);
      #1;
      n_cmp++;
      if (fu_req_tag !== 2'd1) begin
         n_fail++; $display("FAIL ooo_tag1: got %0d want 1", fu_req_tag);
      end
      tick();
      idle();
      out_ready = 1'b1;
      set_resp(0, 2'd1, 32'hbbbb);
      tick();
      idle();
      out_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         #1;
         n_cmp++;
         if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL ooo_hold%0d: got %b want 0", k, out_valid);
         end
         tick();
      end
      set_resp(2, 2'd0, 32'haaaa);
      tick();
      idle();
      out_ready = 1'b1;
      #1;
      n_cmp++;
      if (out_valid !== 1'b1 || out_rd !== 5'd3 || out_data !== 32'haaaa) begin
         n_fail++; $display("FAIL ooo_first: got ov=%b rd=%0d data=%h want 1 3 aaaa",
                            out_valid, out_rd, out_data);
      end
      tick();
      n_cmp++;
      if (out_valid !== 1'b1 || out_rd !== 5'd4 || out_data !== 32'hbbbb) begin
         n_fail++; $display("FAIL ooo_second: got ov=%b rd=%0d data=%h want 1 4 bbbb",
                            out_valid, out_rd, out_data);
      end
      tick();
      n_cmp++;
      if (out_valid !== 1'b0) begin
         n_fail++; $display("FAIL ooo_drained: got %b want 0", out_valid);
      end
      idle();
   endtask

   task automatic test_full();
      do_reset();
      for (int k = 0; k < 4; k++) begin
         set_issue(FU_LSU, 5'(k + 1), 32'h200 + 32'(4 * k));
         #1;
         n_cmp++;
         if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL full_fill%0d: got %b want 1", k, in_ready);
         end
         tick();
         idle();
      end
      set_issue(FU_MUL, 5'd9, 32'h300);
      set_resp(1, 2'd0, 32'h77);
      #1;
      n_cmp++;
      if (in_ready !== 1'b0 || fu_req_valid !== 3'b000) begin
         n_fail++; $display("FAIL full_reject: got rdy=%b v=%b want 0 000", in_ready, fu_req_valid);
      end
      tick();
      idle();
      set_issue(FU_MUL, 5'd9, 32'h300);
      out_ready = 1'b1;
      #1;
      n_cmp++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
         n_fail++; $display("FAIL full_no_bypass: got ov=%b rdy=%b want 1 0", out_valid, in_ready);
      end
      tick();
      idle();
      set_issue(FU_MUL, 5'd9, 32'h300);
      #1;
      n_cmp++;
      if (in_ready !== 1'b1 || fu_req_tag !== 2'd0) begin
         n_fail++; $display("FAIL full_wrap: got rdy=%b tag=%0d want 1 0", in_ready, fu_req_tag);
      end
      tick();
      idle();
      #1;
      n_cmp++;
      if (rd_busy !== 32'h0000_021c) begin
         n_fail++; $display("FAIL full_busy: got %h want 0000021c", rd_busy);
      end
   endtask

   task automatic test_flush();
      do_reset();
      for (int k = 0; k < 3; k++) begin
         set_issue(FU_LSU, 5'(k + 1), 32'h400);
         tick();
      end
      idle();
      set_issue(FU_LSU, 5'd7, 32'h40c);
      flush = 1'b1;
      set_resp(0, 2'd1, 32'hdead);
      #1;
      n_cmp++;
      if (fu_flush !== 1'b1 || in_ready !== 1'b0 || fu_req_valid !== 3'b000 || out_valid !== 1'b0) begin
         n_fail++; $display("FAIL flush_cycle: got ff=%b rdy=%b v=%b ov=%b want 1 0 000 0",
                            fu_flush, in_ready, fu_req_valid, out_valid);
      end
      tick();
      idle();
      #1;
      n_cmp++;
      if (rd_busy !== 32'd0 || fu_flush !== 1'b0 || fu_req_tag !== 2'd0) begin
         n_fail++; $display("FAIL flush_after: got busy=%h ff=%b tag=%0d want 0 0 0",
                            rd_busy, fu_flush, fu_req_tag);
      end
      set_issue(FU_DIV, 5'd6, 32'h500);
      #1;
      n_cmp++;
      if (in_ready !== 1'b1 || fu_req_valid !== 3'b100) begin
         n_fail++; $display("FAIL flush_reissue: got rdy=%b v=%b want 1 100", in_ready, fu_req_valid);
      end
      tick();
      idle();
      #1;
      n_cmp++;
      if (rd_busy !== 32'h40) begin
         n_fail++; $display("FAIL flush_busy: got %h want 40", rd_busy);
      end
   endtask

   task automatic test_dual_resp();
      logic [31:0] want [4];
      want[0] = 32'h0; want[1] = 32'h11; want[2] = 32'h22; want[3] = 32'h33;
      do_reset();
      set_issue(FU_LSU, 5'd0, 32'h600);
      tick();
      idle();
      #1;
      n_cmp++;
      if (rd_busy !== 32'd0) begin
         n_fail++; $display("FAIL dual_rd0: got %h want 0", rd_busy);
      end
      for (int k = 1; k < 4; k++) begin
         set_issue(FU_MUL, 5'(9 + k), 32'h600 + 32'(4 * k));
         tick();
      end
      idle();
      #1;
      n_cmp++;
      if (rd_busy !== 32'h1c00) begin
         n_fail++; $display("FAIL dual_busy: got %h want 1c00", rd_busy);
      end
      set_resp(0, 2'd2, 32'h22);
      set_resp(1, 2'd3, 32'h33);
      tick();
      idle();
      set_resp(2, 2'd0, 32'h0);
      set_resp(0, 2'd1, 32'h11);
      tick();
      idle();
      out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         #1;
         n_cmp++;
         if (out_valid !== 1'b1 || out_data !== want[k]) begin
            n_fail++; $display("FAIL dual_commit%0d: got ov=%b data=%h want 1 %h",
                               k, out_valid, out_data, want[k]);
         end
         tick();
      end
      idle();
   endtask

   task automatic test_reset_mid();
      do_reset();
      set_issue(FU_LSU, 5'd5, 32'h700);
      tick();
      set_issue(FU_MUL, 5'd6, 32'h704);
      set_resp(0, 2'd0, 32'h55);
      tick();
      idle();
      reset = 1'b1;
      set_issue(FU_DIV, 5'd7, 32'h708);
      tick();
      idle();
      #1;
      n_cmp++;
      if (out_valid !== 1'b0 || rd_busy !== 32'd0) begin
         n_fail++; $display("FAIL rstmid_state: got ov=%b busy=%h want 0 0", out_valid, rd_busy);
      end
      reset = 1'b0;
      fu_req_ready = 3'b101;
      in_fu = FU_MUL;
      #1;
      n_cmp++;
      if (in_ready !== 1'b0) begin
         n_fail++; $display("FAIL rstmid_rdy_mul: got %b want 0", in_ready);
      end
      in_fu = FU_DIV;
      #1;
      n_cmp++;
      if (in_ready !== 1'b1) begin
         n_fail++; $display("FAIL rstmid_rdy_div: got %b want 1", in_ready);
      end
      fu_req_ready = 3'b111;
   endtask

   task automatic test_random();
      logic [31:0] eb;
      do_reset();
      for (int cyc = 0; cyc < 800; cyc++) begin
         idle();
         reset = ($urandom_range(0, 99) < 2);
         flush = ($urandom_range(0, 99) < 4);
         in_valid = 1'($urandom_range(0, 1));
         in_fu = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
         in_rd = 5'($urandom_range(0, 31));
         in_pc = $urandom;
         fu_req_ready = 3'($urandom_range(0, 7));
         out_ready = ($urandom_range(0, 3) != 0);
         for (int c = 0; c < NF; c++) begin
            if ($urandom_range(0, 2) == 0) set_resp(c, 2'((m_head + $urandom_range(0, 3)) % D), $urandom);
         end
         #1;
         n_cmp++;
         if (in_ready !== exp_in_ready() || fu_req_valid !== exp_req_valid() ||
             fu_req_tag !== 2'(m_tail) || fu_flush !== flush) begin
            n_fail++; $display("FAIL rand_issue@%0d: got rdy=%b v=%b tag=%0d ff=%b want %b %b %0d %b",
                               cyc, in_ready, fu_req_valid, fu_req_tag, fu_flush,
                               exp_in_ready(), exp_req_valid(), m_tail, flush);
         end
         eb = exp_busy();
         n_cmp++;
         if (rd_busy !== eb || out_valid !== exp_out_valid()) begin
            n_fail++; $display("FAIL rand_state@%0d: got busy=%h ov=%b want %h %b",
                               cyc, rd_busy, out_valid, eb, exp_out_valid());
         end
         if (exp_out_valid()) begin
            n_cmp++;
            if (out_rd !== m_rd[m_head] || out_data !== m_data[m_head] || out_pc !== m_pc[m_head]) begin
               n_fail++; $display("FAIL rand_head@%0d: got rd=%0d data=%h pc=%h want %0d %h %h",
                                  cyc, out_rd, out_data, out_pc,
                                  m_rd[m_head], m_data[m_head], m_pc[m_head]);
            end
         end
         tick();
      end
      idle();
      reset = 1'b0;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_out_of_order();
      test_full();
      test_flush();
      test_dual_resp();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
